// File: rtl/bus_responder_pkg.sv
// Shared constants and types for the bus_responder memory-map target:
// region decode, external-handshake state encoding and RW polarity.
package bus_responder_pkg;

    localparam logic [7:0] C_VEC_BASE_H = 8'hFF;
    localparam logic [7:0] C_VEC_BASE_L = 8'hFA;
    localparam logic [7:0] C_UNMAPPED_DATA = 8'hFF;

    localparam logic C_RW_READ  = 1'b1;
    localparam logic C_RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        C_RESP_IDLE = 2'd0,
        C_RESP_REQ  = 2'd1,
        C_RESP_DONE = 2'd2
    } resp_state_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_VEC  = 2'd1,
        REG_EXT  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Vector pair select: FA/FB -> NMI, FC/FD -> RESET, FE/FF -> IRQ.
    function automatic logic [15:0] vec_word(input logic [1:0] sel,
                                             input logic [15:0] nmi_v,
                                             input logic [15:0] res_v,
                                             input logic [15:0] irq_v);
        case (sel)
            2'b01:   vec_word = nmi_v;
            2'b10:   vec_word = res_v;
            default: vec_word = irq_v;
        endcase
    endfunction

endpackage

// File: rtl/bus_responder_resp_ram.sv
// Internal RAM for bus_responder: asynchronous read, synchronous write.
// Contents are deliberately not reset.
module resp_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/bus_responder.sv
// CPU bus target: decodes vectors / external window / RAM / unmapped, and
// stalls the CPU through RDY while an external REQ/ACK transfer completes.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int          RAM_AW     = 11,
    parameter logic [7:0]  EXT_BASE_H = 8'h40,
    parameter logic [7:0]  EXT_MASK_H = 8'hF0,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] NMI_VEC    = 16'hF000,
    parameter logic [15:0] RESET_VEC  = 16'hF000,
    parameter logic [15:0] IRQ_VEC    = 16'hF000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [7:0]  ABL,
    input  logic [7:0]  ABH,
    input  logic        RW,
    input  logic [7:0]  DB_WR,
    output logic [7:0]  DB_RD,
    output logic        RDY,
    output logic        EXT_REQ,
    output logic        EXT_WE,
    output logic [11:0] EXT_ADDR,
    output logic [7:0]  EXT_WDATA,
    input  logic        EXT_ACK,
    input  logic [7:0]  EXT_RDATA,
    output logic        BUS_ERR,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Handshake: a CPU cycle completes at the edge where RDY=1; while RDY=0 the
    // CPU holds ABL/ABH/RW/DB_WR. EXT_REQ stays high until the one-cycle
    // EXT_ACK (or the timeout) ends the request; EXT_RDATA is sampled only with ACK.

    resp_state_e state_q, state_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [11:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        bus_err_q, bus_err_d;

    region_e     region;
    logic [15:0] addr;
    logic [15:0] vword;
    logic [7:0]  ram_rdata;
    logic        rdy_fsm;
    logic        ram_we;

    assign addr = {ABH, ABL};

    always_comb begin
        region = REG_NONE;
        if (ABH == C_VEC_BASE_H && ABL >= C_VEC_BASE_L) begin
            region = REG_VEC;
        end else if ((ABH & EXT_MASK_H) == EXT_BASE_H) begin
            region = REG_EXT;
        end else if ((32'(addr) >> RAM_AW) == 32'd0) begin
            region = REG_RAM;
        end
    end

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        bus_err_d   = bus_err_q;
        rdy_fsm     = 1'b1;
        case (state_q)
            C_RESP_IDLE: begin
                if (region == REG_EXT) begin
                    rdy_fsm     = 1'b0;
                    ext_addr_d  = {ABH[3:0], ABL};
                    ext_we_d    = (RW == C_RW_WRITE);
                    ext_wdata_d = DB_WR;
                    ext_req_d   = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = C_RESP_REQ;
                end
            end
            C_RESP_REQ: begin
                rdy_fsm = 1'b0;
                if (EXT_ACK) begin
                    data_d    = EXT_RDATA;
                    ext_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = C_RESP_DONE;
                end else if (cnt_q == TO_LAST) begin
                    data_d    = C_UNMAPPED_DATA;
                    bus_err_d = 1'b1;
                    ext_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = C_RESP_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // The CPU advances at this edge, so going straight to IDLE never
            // re-launches the access that just finished.
            C_RESP_DONE: state_d = C_RESP_IDLE;
            default:     state_d = C_RESP_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= C_RESP_IDLE;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= 12'd0;
            ext_wdata_q <= 8'd0;
            cnt_q       <= 8'd0;
            data_q      <= 8'hFF;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign vword = vec_word(ABL[2:1], NMI_VEC, RESET_VEC, IRQ_VEC);

    always_comb begin
        DB_RD = C_UNMAPPED_DATA;
        case (region)
            REG_VEC: DB_RD = ABL[0] ? vword[15:8] : vword[7:0];
            REG_EXT: DB_RD = data_q;
            REG_RAM: DB_RD = ram_rdata;
            default: DB_RD = C_UNMAPPED_DATA;
        endcase
    end

    assign RDY    = RES ? 1'b1 : rdy_fsm;
    assign ram_we = (region == REG_RAM) && (RW == C_RW_WRITE) && RDY;

    resp_ram #(.AW(RAM_AW)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (DB_WR),
        .rdata (ram_rdata)
    );

    assign EXT_REQ   = ext_req_q;
    assign EXT_WE    = ext_we_q;
    assign EXT_ADDR  = ext_addr_q;
    assign EXT_WDATA = ext_wdata_q;
    assign BUS_ERR   = bus_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: randomized CPU cycles and external
// ACK timing checked against a memory-map/latency reference model.
module tb_bus_responder;
    import bus_responder_pkg::*;

    localparam int          TIMEOUT = 16;
    localparam logic [15:0] NMI_V   = 16'hABCD;
    localparam logic [15:0] RES_V   = 16'hC123;
    localparam logic [15:0] IRQ_V   = 16'h5E6F;

    logic        CLK = 1'b0;
    logic        RES, RW, EXT_ACK, RDY, EXT_REQ, EXT_WE, BUS_ERR;
    logic [7:0]  ABL, ABH, DB_WR, DB_RD, EXT_WDATA, EXT_RDATA;
    logic [11:0] EXT_ADDR;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram_m [int];
    logic        bus_err_m;
    logic [11:0] obs_addr;
    logic        obs_we;
    logic [7:0]  obs_wdata;
    int          obs_pulses;
    logic [1:0]  idle_code;

    bus_responder #(
        .RAM_AW(11), .EXT_BASE_H(8'h40), .EXT_MASK_H(8'hF0), .TIMEOUT(TIMEOUT),
        .NMI_VEC(NMI_V), .RESET_VEC(RES_V), .IRQ_VEC(IRQ_V)
    ) dut (
        .CLK(CLK), .RES(RES), .ABL(ABL), .ABH(ABH), .RW(RW), .DB_WR(DB_WR),
        .DB_RD(DB_RD), .RDY(RDY), .EXT_REQ(EXT_REQ), .EXT_WE(EXT_WE),
        .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA), .EXT_ACK(EXT_ACK),
        .EXT_RDATA(EXT_RDATA), .BUS_ERR(BUS_ERR), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    // Reference latency: one decode stall plus REQ cycles until ACK or timeout.
    function automatic int exp_stalls(input int ack_on);
        if (ack_on == 0 || ack_on > TIMEOUT) return TIMEOUT + 1;
        return ack_on + 1;
    endfunction

    function automatic logic [7:0] exp_vec(input logic [15:0] a);
        logic [15:0] words [3];
        int idx;
        words[0] = NMI_V;
        words[1] = RES_V;
        words[2] = IRQ_V;
        idx = (int'(a) - 'hFFFA) / 2;
        return a[0] ? words[idx][15:8] : words[idx][7:0];
    endfunction

    // One CPU cycle, held until RDY. ack_on = REQ cycle number that gets ACK (0 = never).
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input int ack_on, input logic [7:0] ack_data,
                             output int stalls, output logic [7:0] rd);
        int   req_cycles;
        logic prev_req;
        req_cycles = 0;
        stalls     = 0;
        obs_pulses = 0;
        prev_req   = 1'b0;
        ABH = a[15:8]; ABL = a[7:0]; RW = rw; DB_WR = wd; EXT_ACK = 1'b0;
        #1;
        while (RDY !== 1'b1 && stalls <= 300) begin
            if (EXT_REQ === 1'b1) begin
                req_cycles++;
                obs_addr  = EXT_ADDR;
                obs_we    = EXT_WE;
                obs_wdata = EXT_WDATA;
                if (!prev_req) obs_pulses++;
            end
            prev_req  = (EXT_REQ === 1'b1);
            EXT_ACK   = (EXT_REQ === 1'b1) && (req_cycles == ack_on);
            EXT_RDATA = EXT_ACK ? ack_data : 8'($urandom_range(0, 255));
            stalls++;
            @(negedge CLK);
            EXT_ACK = 1'b0;
            #1;
        end
        n_checks++;
        if (RDY !== 1'b1) begin
            n_errors++;
            $display("FAIL rdy_bound addr=%h: RDY still low after %0d cycles, required completion", a, stalls);
        end
        rd = DB_RD;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RES = 1'b1; ABH = 8'h40; ABL = 8'h00; RW = 1'b1; DB_WR = 8'h00;
        EXT_ACK = 1'b0; EXT_RDATA = 8'h00;
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if (RDY !== 1'b1) begin n_errors++; $display("FAIL reset_rdy got %b want 1", RDY); end
        n_checks++; if (EXT_REQ !== 1'b0) begin n_errors++; $display("FAIL reset_req got %b want 0", EXT_REQ); end
        n_checks++; if (EXT_WE !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b want 0", EXT_WE); end
        n_checks++; if (EXT_ADDR !== 12'h000) begin n_errors++; $display("FAIL reset_addr got %h want 000", EXT_ADDR); end
        n_checks++; if (EXT_WDATA !== 8'h00) begin n_errors++; $display("FAIL reset_wdata got %h want 00", EXT_WDATA); end
        n_checks++; if (BUS_ERR !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", BUS_ERR); end
        n_checks++; if (dbg_state !== idle_code) begin n_errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, idle_code); end
        @(negedge CLK);
        ABH = 8'h00;
        RES = 1'b0;
        bus_err_m = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_ram();
        int st; logic [7:0] rd; logic [15:0] a; logic w; logic [7:0] d;
        bus_cycle(16'h01FF, C_RW_WRITE, 8'hA5, 0, 8'h00, st, rd);
        ram_m[16'h01FF] = 8'hA5;
        n_checks++; if (st !== 0) begin n_errors++; $display("FAIL ram_wr_stall got %0d want 0", st); end
        bus_cycle(16'h01FF, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        n_checks++; if (rd !== 8'hA5 || st !== 0) begin n_errors++; $display("FAIL ram_rd got %h/%0d want a5/0", rd, st); end
        bus_cycle(16'h0800, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        n_checks++; if (rd !== 8'hFF || st !== 0) begin n_errors++; $display("FAIL unmapped_0800 got %h/%0d want ff/0", rd, st); end
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 'h7FF));
            if (i < 8) a = 16'h07F8 + 16'(i);
            w = (i % 3 == 0) ? C_RW_READ : 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            bus_cycle(a, w, d, 0, 8'h00, st, rd);
            if (w == C_RW_WRITE) ram_m[int'(a)] = d;
            else if (ram_m.exists(int'(a))) begin
                n_checks++;
                if (rd !== ram_m[int'(a)] || st !== 0) begin
                    n_errors++; $display("FAIL ram_rand addr=%h got %h/%0d want %h/0", a, rd, st, ram_m[int'(a)]);
                end
            end
        end
    endtask

    task automatic test_vectors();
        int st; logic [7:0] rd;
        for (int i = 'hFFFA; i <= 'hFFFF; i++) begin
            bus_cycle(16'(i), C_RW_READ, 8'h00, 0, 8'h00, st, rd);
            n_checks++;
            if (rd !== exp_vec(16'(i)) || st !== 0) begin
                n_errors++; $display("FAIL vec_rd addr=%h got %h want %h", i, rd, exp_vec(16'(i)));
            end
        end
        bus_cycle(16'hFFFC, C_RW_WRITE, 8'h77, 0, 8'h00, st, rd);
        bus_cycle(16'hFFFC, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        n_checks++; if (rd !== 8'h23) begin n_errors++; $display("FAIL vec_wr_ignored got %h want 23", rd); end
        bus_cycle(16'hFFF9, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        n_checks++; if (rd !== 8'hFF) begin n_errors++; $display("FAIL below_vec got %h want ff", rd); end
        bus_cycle(16'h8000, C_RW_WRITE, 8'h12, 0, 8'h00, st, rd);
        bus_cycle(16'h8000, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        n_checks++; if (rd !== 8'hFF || st !== 0) begin n_errors++; $display("FAIL unmapped_8000 got %h/%0d want ff/0", rd, st); end
    endtask

    task automatic test_ext_read();
        int st; logic [7:0] rd;
        bus_cycle(16'h4123, C_RW_READ, 8'h00, 3, 8'h5A, st, rd);
        n_checks++; if (st !== 4) begin n_errors++; $display("FAIL ext_rd_stall got %0d want 4", st); end
        n_checks++; if (rd !== 8'h5A) begin n_errors++; $display("FAIL ext_rd_data got %h want 5a", rd); end
        n_checks++; if (obs_addr !== 12'h123 || obs_we !== 1'b0) begin n_errors++; $display("FAIL ext_rd_addr got %h/%b want 123/0", obs_addr, obs_we); end
        n_checks++; if (BUS_ERR !== 1'b0) begin n_errors++; $display("FAIL ext_rd_err got %b want 0", BUS_ERR); end
    endtask

    task automatic test_back_to_back();
        int st; logic [7:0] rd; int total;
        bus_cycle(16'h4FFF, C_RW_WRITE, 8'h3C, 1, 8'h00, st, rd);
        total = obs_pulses;
        n_checks++; if (st !== 2) begin n_errors++; $display("FAIL b2b_wr_stall got %0d want 2", st); end
        n_checks++; if (obs_we !== 1'b1 || obs_wdata !== 8'h3C || obs_addr !== 12'hFFF) begin
            n_errors++; $display("FAIL b2b_wr got we=%b wd=%h a=%h want 1/3c/fff", obs_we, obs_wdata, obs_addr); end
        bus_cycle(16'h4FFF, C_RW_READ, 8'h00, 2, 8'hC7, st, rd);
        total += obs_pulses;
        n_checks++; if (obs_we !== 1'b0 || rd !== 8'hC7 || st !== 3) begin
            n_errors++; $display("FAIL b2b_rd got we=%b rd=%h st=%0d want 0/c7/3", obs_we, rd, st); end
        n_checks++; if (total !== 2) begin n_errors++; $display("FAIL b2b_pulses got %0d want 2", total); end
    endtask

    task automatic test_random_ext();
        int st; logic [7:0] rd; logic [15:0] a; logic w; int ack; logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            a   = {4'h4, 12'($urandom_range(0, 'hFFF))};
            w   = 1'($urandom_range(0, 1));
            ack = (i == 0) ? TIMEOUT : (i == 1) ? 1 : $urandom_range(1, TIMEOUT);
            d   = 8'($urandom_range(0, 255));
            bus_cycle(a, w, d, ack, d ^ 8'h5B, st, rd);
            n_checks++;
            if (st !== exp_stalls(ack) || obs_addr !== a[11:0] || obs_we !== (w == C_RW_WRITE) ||
                (w == C_RW_READ && rd !== (d ^ 8'h5B)) || (w == C_RW_WRITE && obs_wdata !== d) ||
                obs_pulses !== 1 || BUS_ERR !== bus_err_m) begin
                n_errors++;
                $display("FAIL ext_rand a=%h ack=%0d got st=%0d rd=%h ea=%h we=%b err=%b want st=%0d rd=%h err=%b",
                         a, ack, st, rd, obs_addr, obs_we, BUS_ERR, exp_stalls(ack), d ^ 8'h5B, bus_err_m);
            end
        end
    endtask

    task automatic test_timeout();
        int st; logic [7:0] rd;
        bus_cycle(16'h4456, C_RW_READ, 8'h00, 0, 8'h00, st, rd);
        bus_err_m = 1'b1;
        n_checks++; if (st !== TIMEOUT + 1) begin n_errors++; $display("FAIL to_stall got %0d want %0d", st, TIMEOUT + 1); end
        n_checks++; if (rd !== 8'hFF) begin n_errors++; $display("FAIL to_data got %h want ff", rd); end
        n_checks++; if (BUS_ERR !== bus_err_m) begin n_errors++; $display("FAIL to_err got %b want 1", BUS_ERR); end
        bus_cycle(16'h4010, C_RW_READ, 8'h00, 1, 8'h99, st, rd);
        bus_cycle(16'h0010, C_RW_WRITE, 8'h42, 0, 8'h00, st, rd);
        ram_m[16'h0010] = 8'h42;
        EXT_ACK = 1'b1;
        @(negedge CLK);
        EXT_ACK = 1'b0;
        #1;
        n_checks++; if (BUS_ERR !== bus_err_m || EXT_REQ !== 1'b0) begin
            n_errors++; $display("FAIL to_sticky got err=%b req=%b want 1/0", BUS_ERR, EXT_REQ); end
        @(negedge CLK);
    endtask

    task automatic test_reset_in_req();
        ABH = 8'h41; ABL = 8'h77; RW = C_RW_READ; EXT_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        RES = 1'b0;
        bus_err_m = 1'b0;
        ABH = 8'h00; ABL = 8'h10;
        EXT_ACK = 1'b1; EXT_RDATA = 8'h66;
        #1;
        n_checks++; if (EXT_REQ !== 1'b0 || dbg_state !== idle_code || RDY !== 1'b1) begin
            n_errors++; $display("FAIL rst_req got req=%b st=%0d rdy=%b want 0/%0d/1", EXT_REQ, dbg_state, RDY, idle_code); end
        @(negedge CLK);
        EXT_ACK = 1'b0;
        #1;
        n_checks++; if (EXT_REQ !== 1'b0 || dbg_state !== idle_code || BUS_ERR !== bus_err_m) begin
            n_errors++; $display("FAIL rst_late_ack got req=%b st=%0d err=%b want 0/%0d/0", EXT_REQ, dbg_state, BUS_ERR, idle_code); end
        n_checks++; if (DB_RD !== ram_m[16'h0010]) begin
            n_errors++; $display("FAIL rst_ram got %h want %h", DB_RD, ram_m[16'h0010]); end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_code = C_RESP_IDLE;
        bus_err_m = 1'b0;
        test_reset();
        test_ram();
        test_vectors();
        test_ext_read();
        test_back_to_back();
        test_random_ext();
        test_timeout();
        test_reset_in_req();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
